// File: rtl/cla_serial_addsub.sv
// Nibble-serial add/subtract engine built on a 4-bit carry-look-ahead slice.
// One nibble per cycle, inter-nibble carry held in a register, valid/ready on both sides.
module cla_serial_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   op_a, op_b, work, work_next;
    logic               carry_q;
    logic [CNT_W-1:0]   nib_cnt;
    logic [3:0]         a_nib, b_nib, g, p, c, s_nib;
    logic               last_nib;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last_nib  = (nib_cnt == LAST_NIB);

    // Nibble slice: carries expanded in look-ahead form from carry_q.
    always_comb begin
        a_nib = op_a[{nib_cnt, 2'b00} +: 4];
        b_nib = op_b[{nib_cnt, 2'b00} +: 4];
        g     = a_nib & b_nib;
        p     = a_nib ^ b_nib;
        c[0]  = g[0] | (p[0] & carry_q);
        c[1]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[2]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry_q);
        c[3]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
        s_nib = p ^ {c[2:0], carry_q};
        work_next = work;
        work_next[{nib_cnt, 2'b00} +: 4] = s_nib;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (last_nib) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            work      <= '0;
            carry_q   <= 1'b0;
            nib_cnt   <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a    <= src1;
                    op_b    <= sub_flag ? ~src2 : src2;
                    carry_q <= sub_flag;
                    nib_cnt <= '0;
                end
                CALC: begin
                    work    <= work_next;
                    carry_q <= c[3];
                    nib_cnt <= nib_cnt + 1'b1;
                    // Outputs only ever see the completed word.
                    if (last_nib) begin
                        sum       <= work_next;
                        carry_out <= c[3];
                        overflow  <= c[3] ^ c[2];
                        zero      <= (work_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_addsub.sv
// Directed bench for cla_serial_addsub at WIDTH=16: latency, flags, backpressure,
// mid-operation reset and back-to-back throughput.
module tb_cla_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] src1 = '0;
    logic [15:0] src2 = '0;
    logic        sub_flag = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cla_serial_addsub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .sub_flag(sub_flag), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] es,
                                input logic ec, input logic ev, input logic ez);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " carry"}, 32'(carry_out), 32'(ec));
        check({tag, " ovf"}, 32'(overflow), 32'(ev));
        check({tag, " zero"}, 32'(zero), 32'(ez));
    endtask

    // Called just after the accepting edge: out_valid must rise on the 4th edge,
    // with sum holding its previous value until then.
    task automatic wait_result(input string tag, input logic [15:0] prev);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i < 4) begin
                check({tag, " early valid"}, 32'(out_valid), 32'd0);
                check({tag, " sum held"}, 32'(sum), 32'(prev));
            end else begin
                check({tag, " latency"}, 32'(out_valid), 32'd1);
            end
        end
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " retire valid"}, 32'(out_valid), 32'd0);
        check({tag, " retire ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] es, input logic ec,
                          input logic ev, input logic ez);
        logic [15:0] prev;
        prev = sum;
        src1 = a; src2 = b; sub_flag = s; in_valid = 1'b1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        src1 = 16'hDEAD; src2 = 16'hBEEF;
        wait_result(tag, prev);
        check_result(tag, es, ec, ev, ez);
        retire(tag);
    endtask

    initial begin
        logic [15:0] ra, rb, rbb, es;
        logic        rs, ec, ev, c15;
        logic [16:0] full;
        int          last_accept, waited;

        step();
        step();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check_result("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        run_op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Backpressure with new operands pending on the input side.
        src1 = 16'h0100; src2 = 16'h0200; sub_flag = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result("bp", 16'h7FFF);
        src1 = 16'hAAAA; src2 = 16'h1111; sub_flag = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp valid held", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check_result("bp hold", 16'h0300, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp drop valid", 32'(out_valid), 32'd0);
        check("bp ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        wait_result("bp next", 16'h0300);
        check_result("bp next", 16'hBBBB, 1'b0, 1'b0, 1'b0);
        retire("bp next");

        // Reset pulse during the second CALC cycle.
        src1 = 16'h1234; src2 = 16'h1111; sub_flag = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst no result", 32'(out_valid), 32'd0);
        end
        run_op("sub_zero", 16'h0010, 16'h0010, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back with out_ready high; accepts must be NIBBLES+2 cycles apart.
        out_ready = 1'b1;
        last_accept = 0;
        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            src1 = ra; src2 = rb; sub_flag = rs; in_valid = 1'b1;
            waited = 0;
            while (!in_ready && waited < 20) begin
                step();
                waited++;
            end
            check("b2b ready timeout", 32'(in_ready), 32'd1);
            step();
            if (n > 0) check("b2b spacing", 32'(cyc - last_accept), 32'd6);
            last_accept = cyc;
            waited = 0;
            while (!out_valid && waited < 20) begin
                step();
                waited++;
            end
            check("b2b valid timeout", 32'(out_valid), 32'd1);
            rbb  = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, rbb} + 17'(rs);
            es   = full[15:0];
            ec   = full[16];
            c15  = es[15] ^ ra[15] ^ rbb[15];
            ev   = ec ^ c15;
            check_result("b2b", es, ec, ev, (es == 16'h0000));
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
